hdmi_timing_gen: RTL and testbench
==================================

HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter H_FRONT_PORCH, default 110; H_SYNC, default 40; H_BACK_PORCH, default 220 (pixel clocks).
REQ-003 SHALL have parameter V_ACTIVE, default 720; V_FRONT_PORCH, default 5; V_SYNC, default 5; V_BACK_PORCH, default 20 (lines).
REQ-004 SHALL have parameters HS_POL, VS_POL, default 1, giving the asserted sync level.
REQ-005 SHALL have parameter CNT_W, default 12, counter and coordinate width; CHK_LOG2, default 5, checker square size log2.
REQ-006 SHALL derive localparams H_TOTAL (sum of H terms), V_TOTAL (sum of V terms), H_START = H_SYNC+H_BACK_PORCH, V_START = V_SYNC+V_BACK_PORCH, BAR_W = H_ACTIVE/8.
REQ-007 Ports: clk  in  1  pixel clock; the only clock.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 grey ramp.
REQ-010 solid_rgb  in  24  colour for mode 0, {R,G,B}.
REQ-011 data  out  24  pixel data {R,G,B}; h_sync, v_sync, data_en  out  1 each.
REQ-012 clk_out  out  1  inverted clk; x, y  out  CNT_W  active-area coordinates; frame_start, line_start  out  1  one-cycle pulses.

Function
REQ-013 h_cnt SHALL count 0..H_TOTAL-1 each clk, wrapping to 0; v_cnt SHALL increment when h_cnt = H_TOTAL-1, wrapping 0 after V_TOTAL-1.
REQ-014 Line order SHALL be sync, back porch, active, front porch; same for frames.
REQ-015 Every output except clk_out SHALL be registered and reflect the counter state before the same clk edge (1-cycle latency).
REQ-016 h_sync SHALL equal HS_POL when h_cnt < H_SYNC, else !HS_POL.
REQ-017 v_sync SHALL equal VS_POL when v_cnt < V_SYNC, else !VS_POL; it changes only at h_cnt = 0.
REQ-018 data_en SHALL be 1 iff H_START <= h_cnt <= H_START+H_ACTIVE-1 and V_START <= v_cnt <= V_START+V_ACTIVE-1.
REQ-019 x SHALL be h_cnt-H_START and y SHALL be v_cnt-V_START while data_en is 1; both 0 otherwise.
REQ-020 frame_start SHALL pulse for h_cnt = 0 and v_cnt = 0; line_start SHALL pulse for h_cnt = 0 on every line.
REQ-021 mode and solid_rgb SHALL be sampled only at h_cnt = 0, v_cnt = 0; changes mid-frame SHALL take effect next frame.
REQ-022 data SHALL be 24'h000000 whenever data_en is 0.
REQ-023 Mode 0: data = sampled solid_rgb.
REQ-024 Mode 1: bar index SHALL reset to 0 at first active pixel of each line, advance every BAR_W pixels, saturate at 7; colours 0..7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; no divider SHALL be used.
REQ-025 Mode 2: data = FFFFFF when x[CHK_LOG2] XOR y[CHK_LOG2] is 0, else 000000.
REQ-026 Mode 3: data = {x[7:0], x[7:0], x[7:0]}, wrapping every 256 pixels.
REQ-027 clk_out SHALL be the combinational inverse of clk.

Reset
REQ-028 While rst = 1: h_cnt, v_cnt, x, y = 0; data = 0; data_en, frame_start, line_start = 0; h_sync = !HS_POL; v_sync = !VS_POL; sampled mode = 0, sampled colour = 0.
REQ-029 Reset asserted mid-frame SHALL take effect at the next edge; first edge after release SHALL output state (h_cnt 0, v_cnt 0): frame_start = 1, both syncs asserted.

Verification (bench params: H 16/2/2/4, H_TOTAL 24; V 4/1/1/2, V_TOTAL 8; CHK_LOG2 1)
REQ-030 Release rst -> edge 1: frame_start = 1, line_start = 1, h_sync = 1, v_sync = 1; edge 3: h_sync = 0; edge 25: v_sync = 0; edge 193: next frame_start.
REQ-031 mode 1 -> first data_en = 1 at edge 79 (v_cnt 3, h_cnt 6); per line x 0-1 FFFFFF, 2-3 FFFF00, ..., 14-15 000000; 16 data_en cycles per line, 4 lines per frame.
REQ-032 mode 2 -> line y = 0: x 0-1 FFFFFF, x 2-3 000000, alternating; line y = 2 inverted; data = 0 in blanking.
REQ-033 mode 0, solid_rgb = 123456, switched to mode 3 mid-frame -> rest of frame 123456; next frame data = {x,x,x}, e.g. x = 5 -> 050505.
REQ-034 HS_POL = 0, VS_POL = 0 -> syncs idle 1 in reset, low during sync intervals; all other timing unchanged.
REQ-035 rst pulsed 1 cycle at v_cnt 4, h_cnt 10 -> next edge all outputs at reset values; frame restarts from (0,0) with frame_start one edge after release.

Source files
------------

// File: rtl/hdmi_timing_gen_if.sv
// Video output bundle of the HDMI timing generator: pattern controls in, pixel/sync stream out.
interface hdmi_timing_gen_if #(
  parameter int unsigned CNT_W = 12
);
  logic [1:0]       mode;
  logic [23:0]      solid_rgb;
  logic [23:0]      data;
  logic             h_sync;
  logic             v_sync;
  logic             data_en;
  logic             clk_out;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             frame_start;
  logic             line_start;

  modport master (
    input  mode, solid_rgb,
    output data, h_sync, v_sync, data_en, clk_out, x, y, frame_start, line_start
  );

  modport slave (
    output mode, solid_rgb,
    input  data, h_sync, v_sync, data_en, clk_out, x, y, frame_start, line_start
  );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator with built-in test patterns; all outputs except clk_out are
// registered and describe the counter position held just before the clock edge.
module hdmi_timing_gen #(
  parameter int unsigned H_ACTIVE      = 1280,
  parameter int unsigned H_FRONT_PORCH = 110,
  parameter int unsigned H_SYNC        = 40,
  parameter int unsigned H_BACK_PORCH  = 220,
  parameter int unsigned V_ACTIVE      = 720,
  parameter int unsigned V_FRONT_PORCH = 5,
  parameter int unsigned V_SYNC        = 5,
  parameter int unsigned V_BACK_PORCH  = 20,
  parameter bit          HS_POL        = 1'b1,
  parameter bit          VS_POL        = 1'b1,
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned CHK_LOG2      = 5
) (
  input  logic               clk,
  input  logic               rst,
  hdmi_timing_gen_if.master  vid
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int unsigned H_START = H_SYNC + H_BACK_PORCH;
  localparam int unsigned V_START = V_SYNC + V_BACK_PORCH;
  localparam int unsigned H_END   = H_START + H_ACTIVE - 1;
  localparam int unsigned V_END   = V_START + V_ACTIVE - 1;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt, r_x, r_y, r_bar_cnt;
  logic [2:0]       r_bar_idx;
  logic [1:0]       r_mode;
  logic [23:0]      r_solid, r_data;
  logic             r_h_sync, r_v_sync, r_data_en, r_frame_start, r_line_start;

  logic             w_h_last, w_v_last, w_h_act, w_v_act, w_de, w_origin, w_bar_first;
  logic [CNT_W-1:0] w_x, w_y, w_bar_cnt;
  logic [2:0]       w_bar_idx;
  logic [23:0]      w_bar_rgb, w_pat;

  // Decode of the current counter position
  always_comb begin
    w_h_last    = (r_h_cnt == CNT_W'(H_TOTAL - 1));
    w_v_last    = (r_v_cnt == CNT_W'(V_TOTAL - 1));
    w_h_act     = (r_h_cnt >= CNT_W'(H_START)) && (r_h_cnt <= CNT_W'(H_END));
    w_v_act     = (r_v_cnt >= CNT_W'(V_START)) && (r_v_cnt <= CNT_W'(V_END));
    w_de        = w_h_act && w_v_act;
    w_x         = w_de ? (r_h_cnt - CNT_W'(H_START)) : '0;
    w_y         = w_de ? (r_v_cnt - CNT_W'(V_START)) : '0;
    w_origin    = (r_h_cnt == '0) && (r_v_cnt == '0);
    w_bar_first = (r_h_cnt == CNT_W'(H_START));
    w_bar_idx   = w_bar_first ? 3'd0 : r_bar_idx;
    w_bar_cnt   = w_bar_first ? '0 : r_bar_cnt;
  end

  // Pattern selection; the bar index is tracked by a pixel counter rather than x / BAR_W
  always_comb begin
    w_bar_rgb = 24'h000000;
    case (w_bar_idx)
      3'd0: w_bar_rgb = 24'hFFFFFF;
      3'd1: w_bar_rgb = 24'hFFFF00;
      3'd2: w_bar_rgb = 24'h00FFFF;
      3'd3: w_bar_rgb = 24'h00FF00;
      3'd4: w_bar_rgb = 24'hFF00FF;
      3'd5: w_bar_rgb = 24'hFF0000;
      3'd6: w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
    w_pat = 24'h000000;
    case (r_mode)
      2'd0: w_pat = r_solid;
      2'd1: w_pat = w_bar_rgb;
      2'd2: w_pat = (w_x[CHK_LOG2] ^ w_y[CHK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
      default: w_pat = {w_x[7:0], w_x[7:0], w_x[7:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_bar_cnt     <= '0;
      r_bar_idx     <= 3'd0;
      r_mode        <= 2'd0;
      r_solid       <= 24'h000000;
      r_data        <= 24'h000000;
      r_h_sync      <= ~HS_POL;
      r_v_sync      <= ~VS_POL;
      r_data_en     <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      r_h_cnt <= w_h_last ? '0 : r_h_cnt + CNT_W'(1);
      if (w_h_last) r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);

      r_h_sync      <= (r_h_cnt < CNT_W'(H_SYNC)) ? HS_POL : ~HS_POL;
      r_v_sync      <= (r_v_cnt < CNT_W'(V_SYNC)) ? VS_POL : ~VS_POL;
      r_data_en     <= w_de;
      r_x           <= w_x;
      r_y           <= w_y;
      r_data        <= w_de ? w_pat : 24'h000000;
      r_frame_start <= w_origin;
      r_line_start  <= (r_h_cnt == '0);

      // Pattern controls only change on frame boundaries
      if (w_origin) begin
        r_mode  <= vid.mode;
        r_solid <= vid.solid_rgb;
      end

      if (w_h_act) begin
        if (w_bar_cnt == CNT_W'(BAR_W - 1)) begin
          r_bar_cnt <= '0;
          r_bar_idx <= (w_bar_idx == 3'd7) ? 3'd7 : w_bar_idx + 3'd1;
        end else begin
          r_bar_cnt <= w_bar_cnt + CNT_W'(1);
          r_bar_idx <= w_bar_idx;
        end
      end
    end
  end

  assign vid.data        = r_data;
  assign vid.h_sync      = r_h_sync;
  assign vid.v_sync      = r_v_sync;
  assign vid.data_en     = r_data_en;
  assign vid.x           = r_x;
  assign vid.y           = r_y;
  assign vid.frame_start = r_frame_start;
  assign vid.line_start  = r_line_start;
  assign vid.clk_out     = ~clk;
endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen on a 24x8 raster: patterns, frame-boundary mode sampling,
// sync polarity and mid-frame reset.
module tb_hdmi_timing_gen;
  localparam int unsigned CNT_W   = 12;
  localparam int unsigned H_TOT   = 24;
  localparam int unsigned V_TOT   = 8;
  localparam int unsigned F_EDGES = H_TOT * V_TOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  hdmi_timing_gen_if #(.CNT_W(CNT_W)) vif ();
  hdmi_timing_gen_if #(.CNT_W(CNT_W)) vif_n ();

  hdmi_timing_gen #(
    .H_ACTIVE(16), .H_FRONT_PORCH(2), .H_SYNC(2), .H_BACK_PORCH(4),
    .V_ACTIVE(4),  .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CNT_W), .CHK_LOG2(1)
  ) dut (
    .clk(clk), .rst(rst), .vid(vif.master)
  );

  hdmi_timing_gen #(
    .H_ACTIVE(16), .H_FRONT_PORCH(2), .H_SYNC(2), .H_BACK_PORCH(4),
    .V_ACTIVE(4),  .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CNT_W), .CHK_LOG2(1)
  ) dut_n (
    .clk(clk), .rst(rst), .vid(vif_n.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_pix(input int kind, input int ex, input int ey,
                                          input logic [23:0] solid);
    logic [7:0] g;
    g = 8'(ex);
    case (kind)
      0: return solid;
      1: return bar_rgb(ex / 2);
      2: return ((((ex >> 1) ^ (ey >> 1)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      default: return {g, g, g};
    endcase
  endfunction

  task automatic check_reset(input string tag);
    check({tag, " data"},  32'(vif.data), 32'h0);
    check({tag, " de"},    32'(vif.data_en), 32'h0);
    check({tag, " fs"},    32'(vif.frame_start), 32'h0);
    check({tag, " ls"},    32'(vif.line_start), 32'h0);
    check({tag, " x"},     32'(vif.x), 32'h0);
    check({tag, " y"},     32'(vif.y), 32'h0);
    check({tag, " hs"},    32'(vif.h_sync), 32'h0);
    check({tag, " vs"},    32'(vif.v_sync), 32'h0);
    check({tag, " hs_n"},  32'(vif_n.h_sync), 32'h1);
    check({tag, " vs_n"},  32'(vif_n.v_sync), 32'h1);
  endtask

  // Walks n_edges edges from the frame origin, checking every output against the raster;
  // at edge chg the pattern inputs are changed to exercise next-frame sampling.
  task automatic check_frame(input string name, input int kind, input logic [23:0] solid,
                             input int n_edges, input int chg,
                             input logic [1:0] new_mode, input logic [23:0] new_solid);
    int de_cnt;
    de_cnt = 0;
    for (int e = 1; e <= n_edges; e++) begin
      int h, v, ex, ey;
      bit de;
      string t;
      @(posedge clk);
      @(negedge clk);
      h  = (e - 1) % H_TOT;
      v  = (e - 1) / H_TOT;
      de = (h >= 6) && (h <= 21) && (v >= 3) && (v <= 6);
      ex = de ? h - 6 : 0;
      ey = de ? v - 3 : 0;
      t  = $sformatf("%s e%0d", name, e);
      if (de) de_cnt++;
      check({t, " de"},   32'(vif.data_en), 32'(de));
      check({t, " x"},    32'(vif.x), 32'(ex));
      check({t, " y"},    32'(vif.y), 32'(ey));
      check({t, " data"}, 32'(vif.data), de ? 32'(exp_pix(kind, ex, ey, solid)) : 32'h0);
      check({t, " hs"},   32'(vif.h_sync), 32'(h < 2));
      check({t, " vs"},   32'(vif.v_sync), 32'(v < 1));
      check({t, " fs"},   32'(vif.frame_start), 32'(e == 1));
      check({t, " ls"},   32'(vif.line_start), 32'(h == 0));
      check({t, " hs_n"}, 32'(vif_n.h_sync), 32'(h >= 2));
      check({t, " vs_n"}, 32'(vif_n.v_sync), 32'(v >= 1));
      check({t, " clk_out"}, 32'(vif.clk_out), 32'h1);
      if (e == chg) begin
        vif.mode      = new_mode;
        vif.solid_rgb = new_solid;
      end
    end
    if (n_edges == int'(F_EDGES)) check({name, " de_count"}, 32'(de_cnt), 32'd64);
  endtask

  initial begin
    vif.mode        = 2'd1;
    vif.solid_rgb   = 24'h000000;
    vif_n.mode      = 2'd0;
    vif_n.solid_rgb = 24'h000000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Bars; switch to checkerboard mid-frame, must not disturb this frame
    check_frame("bars", 1, 24'h0, int'(F_EDGES), 100, 2'd2, 24'h0);
    check_frame("checker", 2, 24'h0, int'(F_EDGES), 50, 2'd0, 24'h123456);
    // Solid; grey selected partway through must wait for the next frame
    check_frame("solid", 0, 24'h123456, int'(F_EDGES), 110, 2'd3, 24'h0);
    check_frame("grey", 3, 24'h0, int'(F_EDGES), 0, 2'd0, 24'h0);

    // Reset pulse with the counters at v 4, h 10
    check_frame("pre_rst", 3, 24'h0, 106, 0, 2'd0, 24'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("pulse");
    rst = 1'b0;
    check_frame("post_rst", 3, 24'h0, int'(F_EDGES), 0, 2'd0, 24'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
